// File: rtl/pmem_fetch_unit_if.sv
// Fetch-unit bus bundle: PC request channel, program-ROM port and
// decoder response channel. The slave modport is the fetch unit.
interface pmem_fetch_unit_if;
    logic        req_valid_i;
    logic [23:0] req_addr_i;
    logic        req_ready_o;
    logic        flush_i;
    logic        mem_rd_o;
    logic [22:0] mem_addr_o;
    logic [23:0] mem_rdata_i;
    logic        rsp_valid_o;
    logic [23:0] rsp_instr_o;
    logic [23:0] rsp_addr_o;
    logic        rsp_ready_i;
    logic        addr_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, flush_i, mem_rdata_i, rsp_ready_i,
        output req_ready_o, mem_rd_o, mem_addr_o, rsp_valid_o, rsp_instr_o,
               rsp_addr_o, addr_err_o
    );

    modport master (
        output req_valid_i, req_addr_i, flush_i, mem_rdata_i, rsp_ready_i,
        input  req_ready_o, mem_rd_o, mem_addr_o, rsp_valid_o, rsp_instr_o,
               rsp_addr_o, addr_err_o
    );
endinterface

// File: rtl/pmem_fetch_unit.sv
// Program-memory fetch unit: accepts PC fetch requests, issues single-cycle
// ROM reads and queues returned instructions in a DEPTH-entry FIFO.
// The returning ROM word is bypassed straight to the response port when the
// FIFO is empty, so a response is visible the cycle after acceptance.
// Optional feature macro: PFU_ADDR_CHECK_EN (reject odd PC addresses with a
// one-cycle addr_err_o pulse instead of fetching).
module pmem_fetch_unit #(
    parameter int          DEPTH      = 2,
    parameter logic [23:0] RESET_ADDR = 24'h000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    pmem_fetch_unit_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_occ;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic            r_inflight;
    logic [23:0]     r_if_addr;
    logic [23:0]     r_instr [DEPTH];
    logic [23:0]     r_addr  [DEPTH];

    logic            w_accept;
    logic            w_fetch;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_store;
    logic [CW-1:0]   w_occ_nx;
    logic [CW-1:0]   w_tot_nx;
    state_t          w_state_nx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request side: FULL means occupancy plus in-flight has reached DEPTH.
    assign bus.req_ready_o = (r_state != FULL) & ~bus.flush_i;
    assign w_accept        = bus.req_valid_i & bus.req_ready_o;

`ifdef PFU_ADDR_CHECK_EN
    logic r_addr_err;
    // Odd addresses still retire through the handshake but never reach the ROM.
    assign w_fetch        = w_accept & ~bus.req_addr_i[0];
    assign bus.addr_err_o = r_addr_err;
`else
    assign w_fetch        = w_accept;
    assign bus.addr_err_o = 1'b0;
`endif

    assign bus.mem_rd_o   = w_fetch & rst_ni;
    assign bus.mem_addr_o = bus.req_addr_i[23:1];

    // Head of queue: ROM data bypasses an empty FIFO.
    assign w_bypass        = (r_occ == '0);
    assign bus.rsp_valid_o = (r_state != IDLE);
    assign bus.rsp_instr_o = (w_bypass & r_inflight) ? bus.mem_rdata_i : r_instr[r_rptr];
    assign bus.rsp_addr_o  = (w_bypass & r_inflight) ? r_if_addr : r_addr[r_rptr];

    // Event decode and next-state derivation from accept/push/pop counts.
    always_comb begin
        w_push     = r_inflight;
        w_pop      = bus.rsp_valid_o & bus.rsp_ready_i;
        w_store    = w_push & ~(w_bypass & w_pop);
        w_occ_nx   = r_occ + CW'(w_push) - CW'(w_pop);
        w_tot_nx   = w_occ_nx + CW'(w_fetch);
        w_state_nx = FETCH;
        if (w_tot_nx == '0)
            w_state_nx = IDLE;
        else if (w_tot_nx == CW'(DEPTH))
            w_state_nx = FULL;
    end

    // FSM, FIFO storage and pointers; flush discards everything in one edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_if_addr  <= RESET_ADDR;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_addr[i]  <= RESET_ADDR;
            end
`ifdef PFU_ADDR_CHECK_EN
            r_addr_err <= 1'b0;
`endif
        end else if (bus.flush_i) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
`ifdef PFU_ADDR_CHECK_EN
            r_addr_err <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_occ      <= w_occ_nx;
            r_inflight <= w_fetch;
            if (w_fetch)
                r_if_addr <= bus.req_addr_i;
            if (w_store) begin
                r_instr[r_wptr] <= bus.mem_rdata_i;
                r_addr[r_wptr]  <= r_if_addr;
                r_wptr          <= ptr_inc(r_wptr);
            end
            if (w_pop && !w_bypass)
                r_rptr <= ptr_inc(r_rptr);
`ifdef PFU_ADDR_CHECK_EN
            r_addr_err <= w_accept & bus.req_addr_i[0];
`endif
        end
    end
endmodule

// File: tb/tb_pmem_fetch_unit.sv
// Scoreboard bench for pmem_fetch_unit: the driver pushes expected
// {instr, addr} pairs on each accepted fetch; a monitor pops and compares on
// every response handshake.
module tb_pmem_fetch_unit;
    localparam logic [23:0] RST_A = 24'h00ABC0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pops = 0;
    int   first_pop = 0;
    int   last_pop = 0;
    logic [47:0] exp_q[$];

    pmem_fetch_unit_if bus();

    pmem_fetch_unit #(.DEPTH(2), .RESET_ADDR(RST_A)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom(input logic [22:0] w);
        return (w == 23'h000100) ? 24'hABCDEF : ({1'b0, w} ^ 24'h5A5A5A);
    endfunction

    // Registered ROM model: data valid the cycle after the read strobe.
    always @(posedge clk) if (bus.mem_rd_o) bus.mem_rdata_i <= rom(bus.mem_addr_o);

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every response handshake against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && !bus.flush_i && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL rsp_unexpected: got %h/%h expected none", bus.rsp_instr_o, bus.rsp_addr_o);
            end else begin
                chk("rsp", {bus.rsp_instr_o, bus.rsp_addr_o}, exp_q.pop_front());
            end
            pops++;
            if (pops == 1) first_pop = cyc;
            last_pop = cyc;
        end
    end

    // Offer one request; returns at the negedge after the accepting edge.
    task automatic send(input logic [23:0] a);
        int n = 0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        #1;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            chk("req_timeout", 48'(n), 48'd0);
        end else begin
`ifdef PFU_ADDR_CHECK_EN
            if (a[0]) begin
                chk("odd_no_rd", 48'(bus.mem_rd_o), 48'd0);
            end else begin
                chk("mem_rd", {24'(bus.mem_rd_o), 1'b0, bus.mem_addr_o}, {24'd1, 1'b0, a[23:1]});
                exp_q.push_back({rom(a[23:1]), a});
            end
`else
            chk("mem_rd", {24'(bus.mem_rd_o), 1'b0, bus.mem_addr_o}, {24'd1, 1'b0, a[23:1]});
            exp_q.push_back({rom(a[23:1]), a});
`endif
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.rsp_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Reset state and ready in the first cycle after release.
        chk("rst_valid", 48'(bus.rsp_valid_o), 48'd0);
        chk("rst_head", {bus.rsp_instr_o, bus.rsp_addr_o}, {24'd0, RST_A});
        chk("rst_ready", 48'(bus.req_ready_o), 48'd1);
        chk("rst_err", 48'(bus.addr_err_o), 48'd0);
        chk("rst_mem_rd", 48'(bus.mem_rd_o), 48'd0);
        @(negedge clk);

        // Single fetch with latency 1.
        send(24'h000200);
        #1;
        chk("lat1_valid", 48'(bus.rsp_valid_o), 48'd1);
        drain();
        bus.rsp_ready_i = 1'b0;

        // Backpressure: two buffered, third stalls, order preserved.
        send(24'h000000);
        send(24'h000002);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 24'h000004;
        #1;
        chk("full_ready0", 48'(bus.req_ready_o), 48'd0);
        @(negedge clk);
        #1;
        chk("full_ready0b", 48'(bus.req_ready_o), 48'd0);
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        send(24'h000004);
        drain();
        bus.rsp_ready_i = 1'b1;

        // Streaming: 16 responses on consecutive cycles.
        pops = 0;
        for (int i = 0; i < 16; i++) send(24'(2 * i));
        drain();
        repeat (2) @(negedge clk);
        chk("stream_cnt", 48'(pops), 48'd16);
        chk("stream_span", 48'(last_pop - first_pop), 48'd15);
        bus.rsp_ready_i = 1'b0;

        // Flush with one buffered plus one in flight.
        send(24'h000040);
        send(24'h000042);
        bus.flush_i     = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 24'h000044;
        #1;
        chk("flush_ready", 48'(bus.req_ready_o), 48'd0);
        chk("flush_no_rd", 48'(bus.mem_rd_o), 48'd0);
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_valid0", 48'(bus.rsp_valid_o), 48'd0);
        @(negedge clk);
        #1;
        chk("flush_valid0b", 48'(bus.rsp_valid_o), 48'd0);
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        send(24'h000400);
        #1;
        chk("post_flush_lat", 48'(bus.rsp_valid_o), 48'd1);
        drain();

        // Odd address.
        send(24'h000201);
`ifdef PFU_ADDR_CHECK_EN
        #1;
        chk("err_pulse", 48'(bus.addr_err_o), 48'd1);
        @(negedge clk);
        #1;
        chk("err_once", 48'(bus.addr_err_o), 48'd0);
        chk("odd_no_rsp", 48'(bus.rsp_valid_o), 48'd0);
`else
        #1;
        chk("odd_err0", 48'(bus.addr_err_o), 48'd0);
`endif
        drain();
        bus.rsp_ready_i = 1'b0;

        // Reset while a read is in flight.
        send(24'h000300);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_valid", 48'(bus.rsp_valid_o), 48'd0);
        chk("rst_mid_addr", 48'(bus.rsp_addr_o), 48'(RST_A));
        chk("rst_mid_ready", 48'(bus.req_ready_o), 48'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mid_none", 48'(bus.rsp_valid_o), 48'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
